// File: rtl/pwm_generator.sv
// Dual-channel PWM with period-boundary double-buffered duty words and a period-start strobe.
// Optional duty slew limiting is enabled by defining PWM_GENERATOR_SLEW_LIMIT_EN.
module pwm_generator #(
    parameter int unsigned PWM_RESOLUTION = 16,
    parameter int unsigned CLK_DIV        = 1,
    parameter int unsigned SLEW_STEP      = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [PWM_RESOLUTION-1:0] duty_cycle_l,
    input  logic [PWM_RESOLUTION-1:0] duty_cycle_r,
    output logic                      pwm_l,
    output logic                      pwm_r,
    output logic                      period_start,
    output logic [PWM_RESOLUTION-1:0] duty_active_l,
    output logic [PWM_RESOLUTION-1:0] duty_active_r
);

    localparam int unsigned RES = PWM_RESOLUTION;
    localparam int unsigned PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [RES-1:0] CNT_LAST   = {{(RES-1){1'b1}}, 1'b0};

    // A zero prescale or zero slew step would stall the generator.
    if (CLK_DIV < 1 || SLEW_STEP < 1) begin : g_bad_param
        $error("pwm_generator: CLK_DIV and SLEW_STEP must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [RES-1:0]   r_cnt;
    logic             r_pwm_l;
    logic             r_pwm_r;
    logic             r_period_start;
    logic [RES-1:0]   r_duty_l;
    logic [RES-1:0]   r_duty_r;

    logic             w_tick;
    logic [PW-1:0]    w_presc_nxt;
    logic [RES-1:0]   w_cnt_nxt;
    logic             w_start;
    logic [RES-1:0]   w_duty_l_nxt;
    logic [RES-1:0]   w_duty_r_nxt;

    assign w_tick = (r_presc == PRESC_LAST);

    // Next-state counters; leaving IDLE always lands on counter 0, prescaler 0.
    always_comb begin
        w_presc_nxt = '0;
        w_cnt_nxt   = '0;
        if (r_state == RUN) begin
            w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
            if (!w_tick) begin
                w_cnt_nxt = r_cnt;
            end else if (r_cnt != CNT_LAST) begin
                w_cnt_nxt = r_cnt + RES'(1);
            end
        end
    end

    assign w_start = (w_presc_nxt == '0) && (w_cnt_nxt == '0);

`ifdef PWM_GENERATOR_SLEW_LIMIT_EN
    localparam int unsigned DUTY_MAX  = (2 ** RES) - 1;
    localparam int unsigned STEP_SAT  = (SLEW_STEP > DUTY_MAX) ? DUTY_MAX : SLEW_STEP;
    localparam logic [RES:0] STEP_W   = (RES + 1)'(STEP_SAT);

    // Move old toward tgt by at most STEP_W, never wrapping.
    function automatic logic [RES-1:0] f_slew(input logic [RES-1:0] old, input logic [RES-1:0] tgt);
        logic [RES:0] v_old;
        logic [RES:0] v_tgt;
        logic [RES:0] v_up;
        v_old = {1'b0, old};
        v_tgt = {1'b0, tgt};
        v_up  = v_old + STEP_W;
        if (v_tgt >= v_old) begin
            f_slew = (v_up > v_tgt) ? tgt : RES'(v_up);
        end else begin
            f_slew = ((v_old - v_tgt) > STEP_W) ? RES'(v_old - STEP_W) : tgt;
        end
    endfunction

    assign w_duty_l_nxt = w_start ? f_slew(r_duty_l, duty_cycle_l) : r_duty_l;
    assign w_duty_r_nxt = w_start ? f_slew(r_duty_r, duty_cycle_r) : r_duty_r;
`else
    assign w_duty_l_nxt = w_start ? duty_cycle_l : r_duty_l;
    assign w_duty_r_nxt = w_start ? duty_cycle_r : r_duty_r;
`endif

    // FSM and output registers; en low wins over any period boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_presc        <= '0;
            r_cnt          <= '0;
            r_pwm_l        <= 1'b0;
            r_pwm_r        <= 1'b0;
            r_period_start <= 1'b0;
            r_duty_l       <= '0;
            r_duty_r       <= '0;
        end else if (!en) begin
            r_state        <= IDLE;
            r_presc        <= '0;
            r_cnt          <= '0;
            r_pwm_l        <= 1'b0;
            r_pwm_r        <= 1'b0;
            r_period_start <= 1'b0;
            r_duty_l       <= '0;
            r_duty_r       <= '0;
        end else begin
            r_state        <= RUN;
            r_presc        <= w_presc_nxt;
            r_cnt          <= w_cnt_nxt;
            r_period_start <= w_start;
            r_duty_l       <= w_duty_l_nxt;
            r_duty_r       <= w_duty_r_nxt;
            r_pwm_l        <= (w_cnt_nxt < w_duty_l_nxt);
            r_pwm_r        <= (w_cnt_nxt < w_duty_r_nxt);
        end
    end

    assign pwm_l         = r_pwm_l;
    assign pwm_r         = r_pwm_r;
    assign period_start  = r_period_start;
    assign duty_active_l = r_duty_l;
    assign duty_active_r = r_duty_r;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator with PWM_RESOLUTION=4, CLK_DIV=2 (30-clk period).
// Building with PWM_GENERATOR_SLEW_LIMIT_EN selects the slew sequence instead of the default one.
module tb_pwm_generator;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] duty_cycle_l;
    logic [3:0] duty_cycle_r;
    logic       pwm_l;
    logic       pwm_r;
    logic       period_start;
    logic [3:0] duty_active_l;
    logic [3:0] duty_active_r;

    int n_checks = 0;
    int n_errors = 0;

    pwm_generator #(
        .PWM_RESOLUTION(4),
        .CLK_DIV       (2),
        .SLEW_STEP     (4)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .duty_cycle_l (duty_cycle_l),
        .duty_cycle_r (duty_cycle_r),
        .pwm_l        (pwm_l),
        .pwm_r        (pwm_r),
        .period_start (period_start),
        .duty_active_l(duty_active_l),
        .duty_active_r(duty_active_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full 30-clk period starting at the strobe clk; optional left duty change at clk chg_k.
    task automatic run_period(input int l_hi, input int r_hi, input int al, input int ar,
                              input int chg_k, input logic [3:0] chg_v, input string tag);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk($sformatf("%s pwm_l k%0d", tag, k), 32'(pwm_l), 32'(k < l_hi));
            chk($sformatf("%s pwm_r k%0d", tag, k), 32'(pwm_r), 32'(k < r_hi));
            chk($sformatf("%s strobe k%0d", tag, k), 32'(period_start), 32'(k == 0));
            chk($sformatf("%s act_l k%0d", tag, k), 32'(duty_active_l), 32'(al));
            chk($sformatf("%s act_r k%0d", tag, k), 32'(duty_active_r), 32'(ar));
            if (k == chg_k) duty_cycle_l = chg_v;
        end
    endtask

    task automatic chk_all_off(input string tag);
        chk({tag, " pwm_l"}, 32'(pwm_l), 32'd0);
        chk({tag, " pwm_r"}, 32'(pwm_r), 32'd0);
        chk({tag, " strobe"}, 32'(period_start), 32'd0);
        chk({tag, " act_l"}, 32'(duty_active_l), 32'd0);
        chk({tag, " act_r"}, 32'(duty_active_r), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        duty_cycle_l = 4'd0;
        duty_cycle_r = 4'd0;
        repeat (2) @(negedge clk);
        chk_all_off("rst");
        reset = 1'b0;
        @(negedge clk);
        chk_all_off("idle");

`ifdef PWM_GENERATOR_SLEW_LIMIT_EN
        en           = 1'b1;
        duty_cycle_l = 4'd15;
        run_period(8,  0, 4,  0, -1, 4'd0, "slew_up1");
        run_period(16, 0, 8,  0, -1, 4'd0, "slew_up2");
        run_period(24, 0, 12, 0, -1, 4'd0, "slew_up3");
        run_period(30, 0, 15, 0, -1, 4'd0, "slew_up4");
        duty_cycle_l = 4'd0;
        run_period(22, 0, 11, 0, -1, 4'd0, "slew_dn1");
        run_period(14, 0, 7,  0, -1, 4'd0, "slew_dn2");
        run_period(6,  0, 3,  0, -1, 4'd0, "slew_dn3");
        run_period(0,  0, 0,  0, -1, 4'd0, "slew_dn4");
`else
        // Basic duty, with the right channel at duty 0.
        en           = 1'b1;
        duty_cycle_l = 4'd5;
        run_period(10, 0, 5, 0, -1, 4'd0, "t1a");
        run_period(10, 0, 5, 0, -1, 4'd0, "t1b");

        // Full-scale duty stays high across wraps; right channel independent.
        duty_cycle_l = 4'd15;
        duty_cycle_r = 4'd3;
        for (int p = 0; p < 3; p++) run_period(30, 6, 15, 3, -1, 4'd0, $sformatf("t2p%0d", p));

        // Mid-period change only takes effect next period.
        duty_cycle_l = 4'd5;
        duty_cycle_r = 4'd15;
        run_period(10, 30, 5,  15, 3,  4'd10, "t3a");
        run_period(20, 30, 10, 15, -1, 4'd0,  "t3b");

        // Drop en in the 4th clk of a duty-8 period.
        duty_cycle_l = 4'd8;
        duty_cycle_r = 4'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t4 pwm_l k%0d", k), 32'(pwm_l), 32'd1);
            chk($sformatf("t4 strobe k%0d", k), 32'(period_start), 32'(k == 0));
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_all_off($sformatf("t4 off%0d", k));
        end
        en = 1'b1;
        run_period(16, 0, 8, 0, -1, 4'd0, "t4b");

        // Async reset in the middle of a high pulse.
        duty_cycle_r = 4'd7;
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("t5 pre pwm_l", 32'(pwm_l), 32'd1);
        chk("t5 pre pwm_r", 32'(pwm_r), 32'd1);
        #2;
        reset = 1'b1;
        en    = 1'b0;
        #1;
        chk_all_off("t5 async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_all_off($sformatf("t5 hold%0d", k));
        end
        en = 1'b1;
        run_period(16, 14, 8, 7, -1, 4'd0, "t5b");

        // en falling exactly at a period boundary: no strobe, no load.
        en = 1'b0;
        @(negedge clk);
        chk_all_off("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Dual-channel PWM stage directly downstream of the motor-control duty-cycle stage.
- Converts the registered unsigned duty words for the left and right wheels into glitch-free PWM drive signals for the H-bridge.
- Duty words are double-buffered and take effect only at period boundaries, so mid-period duty changes never produce runt pulses.
- Emits a period-start strobe for downstream timing (tach/ADC alignment, debug).

Parameters:
- PWM_RESOLUTION, 16, width of the duty words and the period counter; period = 2**PWM_RESOLUTION-1 ticks.
- CLK_DIV, 1, clk cycles per counter tick (prescaler); legal range is 1 or more.
- SLEW_STEP, 256, maximum duty change per period when SLEW_LIMIT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low forces outputs off.
- duty_cycle_l  in  PWM_RESOLUTION  requested left duty, unsigned.
- duty_cycle_r  in  PWM_RESOLUTION  requested right duty, unsigned.
- pwm_l  out  1  left PWM drive, registered.
- pwm_r  out  1  right PWM drive, registered.
- period_start  out  1  one-clk pulse in the first clk of every period.
- duty_active_l  out  PWM_RESOLUTION  left duty currently applied.
- duty_active_r  out  PWM_RESOLUTION  right duty currently applied.

Behaviour:
- Reset values: pwm_l/r=0, period_start=0, duty_active_l/r=0, prescaler=0, period counter=0, state=IDLE.
- FSM has two states, IDLE and RUN.
- IDLE:
  - Counters are held at 0; pwm_l/r=0; period_start=0; duty_active_l/r=0.
  - en=1 moves to RUN on the next clk.
- RUN, first clk: period_start=1 and duty_active is loaded from the inputs.
- RUN, prescaler:
  - Counts 0..CLK_DIV-1.
  - A tick occurs on the clk where prescaler==CLK_DIV-1.
- RUN, period counter:
  - Advances on each tick over 0..2**PWM_RESOLUTION-2, then wraps to 0.
- Period timing:
  - A period is (2**PWM_RESOLUTION-1)*CLK_DIV clk.
  - period_start pulses in the clk in which the counter is 0 and prescaler is 0.
- Shadow load:
  - duty_active_l/r load from duty_cycle_l/r in the same clk period_start is high.
  - Inputs are sampled on the preceding edge.
  - Input changes at any other time have no effect until the next period.
- Output timing:
  - pwm_x is high for exactly duty_active_x*CLK_DIV consecutive clk, starting with the period_start clk; it is low for the rest of the period.
  - Realisation: pwm_x is registered from the next-state counter compared against next-state duty, so output and strobe align with no extra latency.
- Duty boundaries:
  - duty=0 keeps pwm low for the whole period.
  - duty=2**PWM_RESOLUTION-1 keeps pwm high continuously across periods, with no dropout at wrap.
- Channels: left and right share one prescaler, one counter and one strobe; they are fully independent otherwise.
- en falling mid-period:
  - Stop is immediate: the next clk is IDLE with pwm_l/r=0 and duty_active=0.
  - The current period is not completed.
- en re-asserted: a fresh period starts from counter 0; there is no phase memory.
- Simultaneous en=0 and period boundary: en wins; no load and no strobe.
- Asynchronous reset mid-period: outputs go low immediately; the FSM returns to IDLE.

Optional Feature:
- Macro: PWM_GENERATOR_SLEW_LIMIT_EN.
- Defined:
  - At each shadow load, duty_active_x moves toward duty_cycle_x by at most SLEW_STEP.
  - Up: new = min(target, old+SLEW_STEP). Down: new = max(target, old-SLEW_STEP).
  - Arithmetic is unsigned with no wrap; compute in PWM_RESOLUTION+1 bits.
  - The RUN entry load starts from old=0, which gives soft-start.
- Undefined: duty_active_x loads the target directly; the SLEW_STEP parameter is ignored.

Test Plan:
- Bench parameters unless noted: PWM_RESOLUTION=4, CLK_DIV=2, so the period is 30 clk.
- Reset then en=1, duty_l=5, duty_r=0 -> period_start every 30 clk; pwm_l high 10 clk from each strobe; pwm_r stays 0.
- duty_l=15 held 3 periods -> pwm_l continuously 1 with no low clk at wraps; duty_active_l=15.
- Change duty_l 5->10 mid-period -> current period still 10 clk high; next period 20 clk high, with duty_active_l updating in the strobe clk.
- Drop en in the 4th clk of a period with duty 8 -> pwm_l 0 on the next clk and held low. Re-raise en -> strobe on the following clk; full 16-clk pulse.
- Assert reset in the middle of a high pulse -> pwm_l/r, duty_active and period_start are 0 within the same cycle; no strobe until en is applied after reset release.
- With SLEW_LIMIT_EN, SLEW_STEP=4, en=1, duty_l=15 -> duty_active_l goes 4, 8, 12, 15 over successive periods. Then duty_l=0 -> 11, 7, 3, 0.
